// File: rtl/l2_writeback_buffer_if.sv
// Line-granular request/response bus. The master issues whole-line reads and writes;
// the slave completes each one with a single-cycle resp (read data valid alongside).
interface l2_writeback_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic              resp;
  logic [LINE_W-1:0] rdata;

  modport master (output read, write, addr, wdata, input resp, rdata);
  modport slave  (input read, write, addr, wdata, output resp, rdata);
endinterface

// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between the L2 memory port and physical memory: absorbs and coalesces
// line evictions, forwards buffered lines to read misses and drains entries in FIFO order.
module l2_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l2_writeback_buffer_if.slave  up,
  l2_writeback_buffer_if.master mem
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              up_resp_q, up_resp_d;
  logic [LINE_W-1:0] up_rdata_q, up_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]  up_tag_s;
  logic [DEPTH-1:0]  hit_vec_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              wr_en_s;
  logic              wr_new_s;
  logic [PTR_W-1:0]  wr_idx_s;
  logic              deq_s;
  logic              unused_addr_s;

  assign up_tag_s      = up.addr[ADDR_W-1:5];
  assign unused_addr_s = ^up.addr[4:0];

  // Parallel tag match; coalescing keeps hit_vec_s one-hot, so an OR-encode gives the index.
  always_comb begin
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_q[i] && (tag_q[i] == up_tag_s);
      hit_idx_s    = hit_idx_s | (hit_vec_s[i] ? PTR_W'(i) : '0);
    end
    hit_s = |hit_vec_s;
  end

  // Next state, queue bookkeeping and next values of the registered bus outputs.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    up_resp_d   = 1'b0;
    up_rdata_d  = up_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en_s     = 1'b0;
    wr_new_s    = 1'b0;
    wr_idx_s    = tail_q;
    deq_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (up.read) begin
          if (hit_s) begin
            up_rdata_d = data_q[hit_idx_s];
            up_resp_d  = 1'b1;
            state_d    = DONE;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = {up_tag_s, 5'b00000};
            state_d    = RD_MEM;
          end
        end else if (up.write && hit_s) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = hit_idx_s;
          up_resp_d = 1'b1;
          state_d   = DONE;
        end else if (up.write && (count_q != FULL_CNT)) begin
          wr_en_s   = 1'b1;
          wr_new_s  = 1'b1;
          tail_d    = tail_q + PTR_W'(1);
          count_d   = count_q + CNT_W'(1);
          up_resp_d = 1'b1;
          state_d   = DONE;
        end else if (up.write || (count_q != '0)) begin
          // Full-with-miss and quiet-with-data both drain the head entry.
          mem_write_d = 1'b1;
          mem_addr_d  = {tag_q[head_q], 5'b00000};
          mem_wdata_d = data_q[head_q];
          state_d     = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      RD_MEM: begin
        if (mem.resp) begin
          mem_read_d = 1'b0;
          up_rdata_d = mem.rdata;
          up_resp_d  = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = RD_MEM;
        end
      end
      DRAIN: begin
        if (mem.resp) begin
          mem_write_d = 1'b0;
          deq_s       = 1'b1;
          head_d      = head_q + PTR_W'(1);
          count_d     = count_q - CNT_W'(1);
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, queue pointers and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      up_resp_q   <= 1'b0;
      up_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      up_resp_q   <= up_resp_d;
      up_rdata_q  <= up_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Entry storage: enqueue and coalesce from upstream, retire the head when its drain completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        data_q[wr_idx_s] <= up.wdata;
      end
      if (wr_new_s) begin
        valid_q[wr_idx_s] <= 1'b1;
        tag_q[wr_idx_s]   <= up_tag_s;
      end
      if (deq_s) begin
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  assign up.resp    = up_resp_q;
  assign up.rdata   = up_rdata_q;
  assign mem.read   = mem_read_q;
  assign mem.write  = mem_write_q;
  assign mem.addr   = mem_addr_q;
  assign mem.wdata  = mem_wdata_q;
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer: upstream request task, a programmable-latency
// memory responder that logs drained lines, and hand-computed expectations.
module tb_l2_writeback_buffer;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  l2_writeback_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) up_if ();
  l2_writeback_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mem_if ();

  l2_writeback_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (up_if.slave),
    .mem   (mem_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model controls (written only by the main sequence)
  bit                mem_auto   = 1'b0;
  int                mem_delay  = 0;
  logic [LINE_W-1:0] mem_rd_val = '0;
  // memory model observations (written only by the responder)
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  int                mem_resp_cyc = 0;
  logic [31:0]       wr_log_addr [$];
  logic [LINE_W-1:0] wr_log_data [$];
  int                up_resp_cyc = 0;

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: pulses resp for one cycle mem_delay cycles after a request is seen.
  initial begin
    int wait_cnt;
    wait_cnt     = 0;
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_if.read === 1'b1) rd_cnt++;
      if (mem_if.write === 1'b1) wr_cnt++;
      if (!rst_n) begin
        mem_if.resp = 1'b0;
        wait_cnt    = 0;
      end else if (mem_if.resp) begin
        mem_if.resp = 1'b0;
      end else if (mem_auto && (mem_if.read || mem_if.write)) begin
        if (wait_cnt >= mem_delay) begin
          mem_if.resp  = 1'b1;
          mem_if.rdata = mem_rd_val;
          mem_resp_cyc = cyc;
          wait_cnt     = 0;
          if (mem_if.write) begin
            wr_log_addr.push_back(mem_if.addr);
            wr_log_data.push_back(mem_if.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic up_req(input logic rd, input logic [31:0] addr, input logic [LINE_W-1:0] wdata,
                        output int lat, output logic [LINE_W-1:0] rdata);
    @(negedge clk);
    up_if.read  = rd;
    up_if.write = ~rd;
    up_if.addr  = addr;
    up_if.wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!up_if.resp && lat < 200);
    rdata       = up_if.rdata;
    up_resp_cyc = cyc;
    check_eq("up_resp_seen", LINE_W'(up_if.resp), LINE_W'(1));
    up_if.read  = 1'b0;
    up_if.write = 1'b0;
  endtask

  task automatic wait_mem(input string tag, input bit wr, input int budget);
    int n;
    n = 0;
    while (((wr ? mem_if.write : mem_if.read) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, LINE_W'(wr ? mem_if.write : mem_if.read), LINE_W'(1));
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (!((dut.count_q == '0) && !mem_if.write && !mem_if.read) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, LINE_W'(dut.count_q), LINE_W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int                lat;
    int                base;
    int                rbase;
    logic [LINE_W-1:0] rd;
    logic [31:0]       a4 [5];

    a4[0] = 32'h0000_4000; a4[1] = 32'h0000_5000; a4[2] = 32'h0000_6000;
    a4[3] = 32'h0000_7000; a4[4] = 32'h0000_9000;
    up_if.read = 1'b0; up_if.write = 1'b0; up_if.addr = '0; up_if.wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_up_resp",   LINE_W'(up_if.resp),    LINE_W'(0));
    check_eq("rst_up_rdata",  up_if.rdata,            LINE_W'(0));
    check_eq("rst_mem_read",  LINE_W'(mem_if.read),   LINE_W'(0));
    check_eq("rst_mem_write", LINE_W'(mem_if.write),  LINE_W'(0));
    check_eq("rst_mem_addr",  LINE_W'(mem_if.addr),   LINE_W'(0));
    check_eq("rst_mem_wdata", mem_if.wdata,           LINE_W'(0));
    rst_n = 1'b1;

    // 1: single write then idle drain, held stable while resp is withheld
    base = wr_log_addr.size();
    up_req(1'b0, 32'h0000_1000, pat(32'hD1D1_0001), lat, rd);
    check_eq("t1_write_lat", LINE_W'(lat), LINE_W'(1));
    check_eq("t1_count", LINE_W'(dut.count_q), LINE_W'(1));
    wait_mem("t1_drain_start", 1'b1, 20);
    check_eq("t1_drain_addr", LINE_W'(mem_if.addr), LINE_W'(32'h0000_1000));
    check_eq("t1_drain_data", mem_if.wdata, pat(32'hD1D1_0001));
    repeat (3) @(negedge clk);
    check_eq("t1_drain_held", LINE_W'(mem_if.write), LINE_W'(1));
    check_eq("t1_addr_held", LINE_W'(mem_if.addr), LINE_W'(32'h0000_1000));
    mem_delay = 0;
    mem_auto  = 1'b1;
    wait_empty("t1_empty", 50);
    check_eq("t1_log_size", LINE_W'(wr_log_addr.size() - base), LINE_W'(1));

    // 2a: read to a line whose drain is in flight waits, then misses to memory
    mem_auto   = 1'b0;
    mem_rd_val = pat(32'hD2D2_0002);
    base  = wr_log_addr.size();
    rbase = rd_cnt;
    up_req(1'b0, 32'h0000_2004, pat(32'hD2D2_0002), lat, rd);
    check_eq("t2a_write_lat", LINE_W'(lat), LINE_W'(1));
    wait_mem("t2a_drain_start", 1'b1, 20);
    fork
      up_req(1'b1, 32'h0000_2000, '0, lat, rd);
      begin
        repeat (5) @(negedge clk);
        mem_auto = 1'b1;
      end
    join
    check_eq("t2a_read_waited", LINE_W'(lat > 5), LINE_W'(1));
    check_eq("t2a_rdata", rd, pat(32'hD2D2_0002));
    check_eq("t2a_drain_addr", LINE_W'(wr_log_addr[base]), LINE_W'(32'h0000_2000));
    check_eq("t2a_mem_read_used", LINE_W'(rd_cnt > rbase), LINE_W'(1));
    wait_empty("t2a_empty", 50);

    // 2b: read hit before the drain starts is served from the buffer
    mem_auto   = 1'b0;
    mem_rd_val = pat(32'hDEAD_0002);
    base  = wr_log_addr.size();
    rbase = rd_cnt;
    up_req(1'b0, 32'h0000_2004, pat(32'hD2D2_0002), lat, rd);
    up_req(1'b1, 32'h0000_2000, '0, lat, rd);
    check_eq("t2b_hit_lat", LINE_W'(lat), LINE_W'(1));
    check_eq("t2b_hit_rdata", rd, pat(32'hD2D2_0002));
    check_eq("t2b_no_mem_read", LINE_W'(rd_cnt - rbase), LINE_W'(0));
    mem_auto = 1'b1;
    wait_empty("t2b_empty", 50);
    check_eq("t2b_drain_data", wr_log_data[base], pat(32'hD2D2_0002));

    // 3: back-to-back writes to one line coalesce into a single drain
    mem_auto = 1'b0;
    base = wr_log_addr.size();
    up_req(1'b0, 32'h0000_3000, pat(32'hD3D3_0003), lat, rd);
    up_req(1'b0, 32'h0000_3000, pat(32'hD4D4_0004), lat, rd);
    check_eq("t3_coalesce_lat", LINE_W'(lat), LINE_W'(1));
    check_eq("t3_count", LINE_W'(dut.count_q), LINE_W'(1));
    mem_auto = 1'b1;
    wait_empty("t3_empty", 50);
    check_eq("t3_log_size", LINE_W'(wr_log_addr.size() - base), LINE_W'(1));
    check_eq("t3_drain_addr", LINE_W'(wr_log_addr[base]), LINE_W'(32'h0000_3000));
    check_eq("t3_drain_data", wr_log_data[base], pat(32'hD4D4_0004));

    // 4: five distinct lines into four entries; fifth waits for one drain; FIFO order kept
    mem_delay = 10;
    base = wr_log_addr.size();
    for (int i = 0; i < 5; i++) begin
      up_req(1'b0, a4[i], pat(a4[i] ^ 32'hA5A5_0000), lat, rd);
      if (i < 4) check_eq("t4_accept_lat", LINE_W'(lat), LINE_W'(1));
    end
    check_eq("t4_fifth_waits", LINE_W'(lat > 10), LINE_W'(1));
    check_eq("t4_one_drain_first", LINE_W'(wr_log_addr.size() - base), LINE_W'(1));
    wait_empty("t4_empty", 300);
    check_eq("t4_log_size", LINE_W'(wr_log_addr.size() - base), LINE_W'(5));
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_order_addr", LINE_W'(wr_log_addr[base + i]), LINE_W'(a4[i]));
      check_eq("t4_order_data", wr_log_data[base + i], pat(a4[i] ^ 32'hA5A5_0000));
    end
    check_eq("t4_head_wrap", LINE_W'(dut.head_q), LINE_W'(1));
    check_eq("t4_tail_wrap", LINE_W'(dut.tail_q), LINE_W'(1));

    // 5: read miss on an empty buffer goes to memory, data returned the cycle after mem resp
    mem_delay  = 3;
    mem_rd_val = pat(32'h5A5A_0008);
    base = wr_log_addr.size();
    fork
      up_req(1'b1, 32'h0000_8010, '0, lat, rd);
      begin
        wait_mem("t5_mem_read", 1'b0, 20);
        check_eq("t5_mem_addr", LINE_W'(mem_if.addr), LINE_W'(32'h0000_8000));
        check_eq("t5_no_write", LINE_W'(mem_if.write), LINE_W'(0));
      end
    join
    check_eq("t5_rdata", rd, pat(32'h5A5A_0008));
    check_eq("t5_resp_after_mem", LINE_W'(up_resp_cyc - mem_resp_cyc), LINE_W'(1));
    check_eq("t5_no_drain", LINE_W'(wr_log_addr.size() - base), LINE_W'(0));

    // 6: reset during a drain drops it and discards the buffer
    mem_auto = 1'b0;
    up_req(1'b0, 32'h0000_A000, pat(32'hDADA_000A), lat, rd);
    wait_mem("t6_drain_start", 1'b1, 20);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_mem_write", LINE_W'(mem_if.write), LINE_W'(0));
    check_eq("t6_rst_count", LINE_W'(dut.count_q), LINE_W'(0));
    check_eq("t6_rst_mem_addr", LINE_W'(mem_if.addr), LINE_W'(0));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    mem_delay = 0;
    mem_auto  = 1'b1;
    rbase = wr_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_no_write_after", LINE_W'(wr_cnt - rbase), LINE_W'(0));
    check_eq("t6_up_resp_quiet", LINE_W'(up_if.resp), LINE_W'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
- Line-granular write-back buffer between the L2 cache's physical-memory port and physical memory.
- Absorbs L2 evictions in one cycle and coalesces repeat evictions to the same line.
- Forwards buffered lines to L2 read misses and issues other read misses to memory.
- Drains buffered lines to memory in FIFO order when the upstream port is quiet or a write needs a slot.

Parameters:
DEPTH, 4, number of line entries (power of two, >=2)
ADDR_W, 32, address width
LINE_W, 256, line width (32-byte lines, offset bits [4:0])

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
up_read  in  1  L2 line read request, held until up_resp
up_write  in  1  L2 line write (eviction) request, held until up_resp
up_addr  in  ADDR_W  L2 request address; bits [4:0] ignored
up_wdata  in  LINE_W  eviction data
up_resp  out  1  one-cycle completion pulse to L2
up_rdata  out  LINE_W  read data, valid while up_resp=1
mem_read  out  1  physical memory read request
mem_write  out  1  physical memory write request
mem_addr  out  ADDR_W  memory address, bits [4:0] always 0
mem_wdata  out  LINE_W  memory write data
mem_resp  in  1  memory completion
mem_rdata  in  LINE_W  memory read data

Behaviour:
- Storage: DEPTH entries {valid, tag=addr[31:5], data}, FIFO head/tail pointers (wrap modulo DEPTH), count 0..DEPTH.
- Hit: parallel tag compare across valid entries. At most one entry per tag; coalescing guarantees this.
- Reset (async, rst_n=0):
  - up_resp, mem_read, mem_write = 0; mem_addr, mem_wdata, up_rdata = 0.
  - All valid bits cleared, count=0, pointers=0, state=IDLE.
  - Reset mid-transaction drops the in-flight request immediately; buffered data is discarded.
- Outputs are Moore-style: derived from registered state and registers only, with no combinational path from up_* to mem_*.
- States:
  - IDLE, evaluated in priority order:
    1. up_read hit: up_rdata <= entry data -> DONE.
    2. up_read miss: latch {up_addr[31:5],5'b0} -> RD_MEM.
    3. up_write hit: overwrite that entry's data -> DONE.
    4. up_write miss, count<DEPTH: enqueue at tail, count+1 -> DONE.
    5. up_write miss with count==DEPTH, or no request with count>0 -> DRAIN.
    6. Otherwise stay in IDLE.
    - If up_read and up_write are both high, the read wins.
  - RD_MEM: mem_read=1, mem_addr=latched address. On mem_resp: up_rdata <= mem_rdata -> DONE.
  - DRAIN: mem_write=1, mem_addr={head tag,5'b0}, mem_wdata=head data, all held stable. On mem_resp: clear head valid, head+1, count-1 -> IDLE.
  - DONE: up_resp=1 for exactly one cycle; the upstream request is ignored this cycle -> IDLE.
- Latency:
  - Write accept, write coalesce and read hit: up_resp in the cycle after the request is first seen in IDLE.
  - Read miss: up_resp in the cycle after mem_resp.
- Drain and upstream interaction:
  - An upstream request arriving during DRAIN waits; it is evaluated in the IDLE cycle after the drain completes.
  - A write to the line being drained is therefore a miss afterwards and is enqueued fresh. Drain data is never modified in flight.
  - Read misses never alias buffered lines, so issuing them ahead of pending drains preserves memory consistency.
- Full and empty:
  - Full (count==DEPTH) with a write miss performs exactly one drain, then accepts the write.
  - Empty: no mem_write is ever asserted.
- Ordering: memory sees drained lines in enqueue order. A coalesced write keeps its original queue position.

Test Plan:
- Reset, write 0x00001000/D1 -> up_resp pulse 1 cycle later. Then, with no request, mem_write=1, mem_addr=0x00001000, mem_wdata=D1 until mem_resp. Count returns to 0.
- Write 0x00002004/D2, then read 0x00002000 while the drain is blocked by withheld mem_resp -> the read waits for the drain to finish. Repeat with the drain not yet started (read issued in the IDLE cycle after DONE) -> up_rdata=D2, mem_read never asserted.
- Back-to-back writes 0x00003000/D3 then 0x00003000/D4 -> count=1; a single drain to 0x00003000 with data D4.
- DEPTH=4, 5 distinct-line writes back-to-back, mem_resp 10 cycles after each request -> fifth up_resp only after the first drain's mem_resp. Memory write addresses follow enqueue order; pointers wrap correctly.
- Empty buffer, read 0x00008010 -> mem_read=1, mem_addr=0x00008000. mem_resp with data X -> up_resp next cycle with up_rdata=X.
- rst_n=0 while mem_write=1 -> mem_write=0 immediately, count=0. After release, no further mem_write occurs.
